aes_req_scheduler: RTL and testbench

//   Shares one fully pipelined aes_128 core among NUM_REQ requesters.
//   - Round-robin arbitration; at most one (state,key) issued per cycle.
//   - Tracks each in-flight operation's requester id through the core latency.
//   - Returns ciphertexts through a credit-protected response FIFO, so no result is ever dropped.
//   - Sits between the requester fabric and the aes_128 instance.

---
 rtl/aes_req_scheduler_if.sv | 30 +++
 rtl/aes_req_scheduler.sv | 95 +++++++++
 tb/tb_aes_req_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_req_scheduler_if.sv
// Requester fabric, aes_128 core and response consumer signals of the AES request scheduler.
// The scheduler takes the slave modport; whatever drives requests and models the core takes master.
interface aes_req_scheduler_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0][127:0]  req_state;
  logic [NUM_REQ-1:0][127:0]  req_key;
  logic [127:0]               core_state;
  logic [127:0]               core_key;
  logic [127:0]               core_out;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [ID_W-1:0]            resp_id;
  logic [127:0]               resp_data;
  logic                       busy;

  modport master (
    output req_valid, req_state, req_key, core_out, resp_ready,
    input  req_ready, core_state, core_key, resp_valid, resp_id, resp_data, busy
  );

  modport slave (
    input  req_valid, req_state, req_key, core_out, resp_ready,
    output req_ready, core_state, core_key, resp_valid, resp_id, resp_data, busy
  );
endinterface

// File: rtl/aes_req_scheduler.sv
// Round-robin front end sharing one pipelined aes_128 core between NUM_REQ requesters,
// with a requester-id tracker and a credit-protected in-order response FIFO.
module aes_req_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_req_scheduler_if.slave   bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [127:0]    data;
  } resp_t;

  logic [ID_W-1:0]             rr_ptr, win_id;
  logic                        win_vld, credit_ok, xfer, push, pop, fifo_empty;
  logic [CNT_W-1:0]            inflight_cnt, fifo_cnt;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [LATENCY:0]            vld_pipe;
  logic [LATENCY:0][ID_W-1:0]  id_pipe;
  resp_t                       mem [FIFO_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every issued op owns a FIFO slot until popped, so a push can never find the FIFO full.
  assign credit_ok = ({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(FIFO_DEPTH);

  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_vld && bus.req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  assign xfer = win_vld & credit_ok & rst;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = xfer && (win_id == ID_W'(gi));
  end

  // Stage LATENCY lines up with the core result for the op issued LATENCY edges earlier.
  assign push       = vld_pipe[LATENCY];
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && bus.resp_ready;

  assign bus.resp_valid = !fifo_empty;
  assign bus.resp_id    = fifo_empty ? '0 : mem[rd_ptr].id;
  assign bus.resp_data  = fifo_empty ? '0 : mem[rd_ptr].data;
  assign bus.busy       = (inflight_cnt != '0) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr         <= '0;
      bus.core_state <= '0;
      bus.core_key   <= '0;
      vld_pipe       <= '0;
      inflight_cnt   <= '0;
      fifo_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[LATENCY-1:0], xfer};
      inflight_cnt <= inflight_cnt + CNT_W'(xfer) - CNT_W'(push);
      fifo_cnt     <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (xfer) begin
        rr_ptr         <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        bus.core_state <= bus.req_state[win_id];
        bus.core_key   <= bus.req_key[win_id];
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Data path: no reset needed, validity lives in vld_pipe and the FIFO counters.
  always_ff @(posedge clk) begin
    id_pipe <= {id_pipe[LATENCY-1:0], win_id};
    if (rst && push) mem[wr_ptr] <= '{id: id_pipe[LATENCY], data: bus.core_out};
  end
endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed bench for aes_req_scheduler with a behavioural LATENCY-deep core stand-in.
// The core stand-in returns the FIPS-197 ciphertext for the FIPS vector and a keyed mix otherwise.
module tb_aes_req_scheduler;
  localparam int NUM_REQ    = 4;
  localparam int LATENCY    = 21;
  localparam int FIFO_DEPTH = 32;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_req_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  aes_req_scheduler #(
    .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ {k[63:0], k[127:64]} ^ 128'hc3a5_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2;
  endfunction

  logic [127:0] cpipe [1:LATENCY];
  always @(posedge clk) begin
    cpipe[1] <= core_fn(bus.core_state, bus.core_key);
    for (int k = 2; k <= LATENCY; k++) cpipe[k] <= cpipe[k-1];
  end
  assign bus.core_out = cpipe[LATENCY];

  int           gnt_q [$];
  int           rid_q [$];
  logic [127:0] rdat_q [$];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) gnt_q.push_back(i);
      if (bus.resp_valid && bus.resp_ready) begin
        rid_q.push_back(int'(bus.resp_id));
        rdat_q.push_back(bus.resp_data);
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [127:0] st [NUM_REQ];
  logic [127:0] kt [NUM_REQ];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_valid(input logic [NUM_REQ-1:0] v);
    bus.req_valid = v;
    #1;
  endtask

  task automatic clear_q;
    gnt_q.delete();
    rid_q.delete();
    rdat_q.delete();
  endtask

  task automatic do_reset;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    clear_q();
  endtask

  // Edges from the acceptance edge until resp_valid is seen high (bounded).
  task automatic wait_resp(output int n);
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_count(input int n, input int lim);
    int c;
    c = 0;
    while (rid_q.size() < n && c < lim) begin
      step(1);
      c++;
    end
  endtask

  // With every requester valid from a zeroed pointer, issue k goes to requester k mod NUM_REQ.
  task automatic check_order(input string pfx, input int n_exp);
    int id;
    check({pfx, "_n_gnt"}, 128'(gnt_q.size()), 128'(n_exp));
    check({pfx, "_n_rsp"}, 128'(rid_q.size()), 128'(n_exp));
    for (int k = 0; k < n_exp; k++) begin
      id = k % NUM_REQ;
      if (k < gnt_q.size())
        check($sformatf("%s_gnt%0d", pfx, k), 128'(gnt_q[k]), 128'(id));
      if (k < rid_q.size()) begin
        check($sformatf("%s_id%0d", pfx, k), 128'(rid_q[k]), 128'(id));
        check($sformatf("%s_data%0d", pfx, k), rdat_q[k], core_fn(st[id], kt[id]));
      end
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_req_ready"},  128'(bus.req_ready), 128'(0));
    check({pfx, "_core_state"}, bus.core_state, 128'(0));
    check({pfx, "_core_key"},   bus.core_key, 128'(0));
    check({pfx, "_resp_valid"}, 128'(bus.resp_valid), 128'(0));
    check({pfx, "_resp_id"},    128'(bus.resp_id), 128'(0));
    check({pfx, "_resp_data"},  bus.resp_data, 128'(0));
    check({pfx, "_busy"},       128'(bus.busy), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    st[0] = FIPS_PT;                                   kt[0] = FIPS_KEY;
    st[1] = 128'h0123456789abcdef_fedcba9876543210;    kt[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    st[2] = 128'hdeadbeef_cafef00d_01020304_a5a5a5a5;  kt[2] = 128'h0f0e0d0c0b0a09080706050403020100;
    st[3] = 128'h8000_0000_0000_0000_0000_0000_0000_0001; kt[3] = 128'hffff_0000_ffff_0000_1234_5678_9abc_def0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_state[i] = st[i];
      bus.req_key[i]   = kt[i];
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;

    // Reset state
    rst = 1'b0;
    step(2);
    check_zero_outputs("rst");
    rst = 1'b1;
    clear_q();

    // 1: single FIPS-197 request from requester 0
    set_valid(4'b0001);
    check("t1_ready", 128'(bus.req_ready), 128'(4'b0001));
    step(1);
    set_valid(4'b0000);
    check("t1_core_state", bus.core_state, FIPS_PT);
    check("t1_core_key", bus.core_key, FIPS_KEY);
    wait_resp(n);
    check("t1_latency", 128'(n), 128'(LATENCY + 1));
    check("t1_resp_id", 128'(bus.resp_id), 128'(0));
    check("t1_resp_data", bus.resp_data, FIPS_CT);
    bus.resp_ready = 1'b1;
    step(1);
    check("t1_idle", 128'({bus.resp_valid, bus.busy}), 128'(0));

    // 2: all requesters valid, consumer always ready
    do_reset();
    bus.resp_ready = 1'b1;
    set_valid('1);
    step(8);
    set_valid('0);
    wait_count(8, 200);
    check_order("t2", 8);

    // 3 + 4: stalled consumer fills the credit, then one pop lets exactly one more in
    do_reset();
    set_valid('1);
    step(70);
    check("t3_accepts", 128'(gnt_q.size()), 128'(FIFO_DEPTH));
    check("t3_ready_lo", 128'(bus.req_ready), 128'(0));
    check("t3_busy", 128'(bus.busy), 128'(1));
    bus.resp_ready = 1'b1;
    step(1);
    bus.resp_ready = 1'b0;
    #1;
    check("t4_regrant", 128'(bus.req_ready), 128'(4'b0001));
    step(1);
    check("t4_ready_lo", 128'(bus.req_ready), 128'(0));
    check("t4_accepts", 128'(gnt_q.size()), 128'(FIFO_DEPTH + 1));
    check("t4_one_pop", 128'(rid_q.size()), 128'(1));
    set_valid('0);
    bus.resp_ready = 1'b1;
    wait_count(FIFO_DEPTH + 1, 200);
    check_order("t3", FIFO_DEPTH + 1);

    // 5: reset with 10 ops in flight and 3 responses queued
    do_reset();
    set_valid('1);
    step(3);
    set_valid('0);
    step(20);
    set_valid('1);
    step(10);
    set_valid('0);
    check("t5_pre_accepts", 128'(gnt_q.size()), 128'(13));
    check("t5_pre_valid", 128'(bus.resp_valid), 128'(1));
    check("t5_pre_busy", 128'(bus.busy), 128'(1));
    rst = 1'b0;
    step(1);
    check_zero_outputs("t5");
    rst = 1'b1;
    clear_q();
    bus.resp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (bus.resp_valid) cnt++;
    end
    check("t5_no_resp_valid", 128'(cnt), 128'(0));
    check("t5_no_resp", 128'(rid_q.size()), 128'(0));
    bus.resp_ready = 1'b0;
    set_valid(4'b0010);
    step(1);
    set_valid('0);
    wait_resp(n);
    check("t5_new_latency", 128'(n), 128'(LATENCY + 1));
    check("t5_new_id", 128'(bus.resp_id), 128'(1));
    check("t5_new_data", bus.resp_data, core_fn(st[1], kt[1]));

    // 6: pointer at 3 with only requester 2 valid wraps to 2 and leaves the pointer at 3
    do_reset();
    bus.resp_ready = 1'b1;
    set_valid(4'b0100);
    check("t6_first", 128'(bus.req_ready), 128'(4'b0100));
    step(1);
    set_valid(4'b0100);
    check("t6_wrap", 128'(bus.req_ready), 128'(4'b0100));
    step(1);
    check("t6_core_state", bus.core_state, st[2]);
    set_valid(4'b1010);
    check("t6_ptr3", 128'(bus.req_ready), 128'(4'b1000));
    set_valid('0);
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
